// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch unit: FSM encoding, word and queue-entry types.
package ifetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } ifetch_state_t;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/ifetch_unit_fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries between fetch and decode.
// Flush wins over push and pop in the same cycle.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; only pointers and count
  // carry state, and stale entries are never visible while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: PC, imem addressing, fetch queue, redirect/halt FSM.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned redirects via fetch_fault.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int          IMEM_AW  = 6,
  parameter int          FQ_DEPTH = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_a,
  input  logic [31:0]        imem_rd,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               halt_req,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [31:0]        out_pc,
  output logic               fetch_fault
);

  localparam logic [1:0] ST_BOOT = S_BOOT;
  localparam logic [1:0] ST_RUN  = S_RUN;
  localparam logic [1:0] ST_HALT = S_HALT;

  localparam int               CNT_W     = $clog2(FQ_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FQ_DEPTH);

  logic [1:0]       state;
  word_t            pc;
  word_t            target_pc;
  logic             misaligned;
  logic             push;
  logic             pop;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_wdata;
  fetch_entry_t     q_head;

  assign imem_a    = pc[IMEM_AW+1:2];
  assign out_valid = !q_empty;
  assign pop       = out_valid && out_ready;
  assign push      = (state == ST_RUN) && !redirect_valid &&
                     ((q_count < DEPTH_CNT) || (q_full && pop));
  assign q_wdata   = '{pc: pc, instr: imem_rd};

  // Outputs read as zero while empty so reset and flush never expose stale storage.
  assign out_instr = out_valid ? q_head.instr : '0;
  assign out_pc    = out_valid ? q_head.pc    : '0;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_q;

  assign misaligned  = (redirect_pc[1:0] != 2'b00);
  assign target_pc   = redirect_pc;
  assign fetch_fault = fault_q;

  always_ff @(posedge clk) begin
    if (reset)               fault_q <= 1'b0;
    else if (redirect_valid) fault_q <= misaligned;
  end
`else
  logic unused_pc_lsb;

  assign misaligned    = 1'b0;
  assign target_pc     = {redirect_pc[31:2], 2'b00};
  assign fetch_fault   = 1'b0;
  assign unused_pc_lsb = ^redirect_pc[1:0];
`endif

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (q_wdata),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Redirect outranks halt and normal sequencing; a trapped redirect keeps pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
    end else if (redirect_valid) begin
      if (misaligned) begin
        state <= ST_HALT;
      end else begin
        state <= ST_RUN;
        pc    <= target_pc;
      end
    end else begin
      if (push) pc <= pc + PC_STEP;
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN:  if (halt_req) state <= ST_HALT;
        default: ;
      endcase
    end
  end

endmodule
